// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   First-word-fall-through result FIFO behind the shifter/ALU. Each accepted
//   word is stored with its overflow bit. The head entry is presented
//   combinationally. A sticky overflow flag and a saturating overflow event
//   counter are kept for the consumer and for debug.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  producer handshake; in_data + in_overflow form the entry
//   out_valid/out_ready consumer handshake; out_data + out_overflow show the head
//   count              occupancy 0..DEPTH
//   sticky_ovf         set by any accepted overflowed write
//   ovf_count          saturating count of accepted overflowed writes
//   clr_sticky         synchronous clear of sticky_ovf and ovf_count
module alu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow,
  output logic [AW:0]      count,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_sticky
);

  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Storage is deliberately not reset; validity comes from count_q alone.
  logic [WIDTH:0]    mem [DEPTH];
  logic [WIDTH:0]    head;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  logic              full;
  logic              wr_fire;
  logic              rd_fire;
  logic              ovf_event;

  assign full      = (count_q == FULL_CNT);
  // Gated by rst so the producer sees not-ready for the whole reset pulse.
  assign in_ready  = !rst && !full;
  assign out_valid = (count_q != '0);

  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign ovf_event = wr_fire && in_overflow;

  assign head         = mem[rd_ptr_q];
  assign out_data     = out_valid ? head[WIDTH-1:0] : '0;
  assign out_overflow = out_valid ? head[WIDTH]     : 1'b0;

  assign count      = count_q;
  assign sticky_ovf = sticky_q;
  assign ovf_count  = ovf_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    ovf_cnt_d = ovf_cnt_q;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A coinciding overflowed write wins over the clear.
    if (ovf_event)       sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;

    if (clr_sticky)
      ovf_cnt_d = ovf_event ? CNT_W'(1) : '0;
    else if (ovf_event && (ovf_cnt_q != CNT_MAX))
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= {in_overflow, in_data};
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
//   Directed bench for alu_result_fifo. Inputs are driven and outputs sampled
//   at the falling edge; a reference queue holds the expected FIFO contents.
module tb_alu_result_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_overflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;
  logic [AW:0]      count;
  logic             sticky_ovf;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_sticky = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [16:0] mq[$];
  logic        m_sticky = 1'b0;
  int          m_cnt    = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_overflow(out_overflow),
    .count(count), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
    .clr_sticky(clr_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Logical left shift of a 16-bit operand; overflow when any 1 is shifted out.
  function automatic logic [16:0] shl(input logic [15:0] a, input int b);
    logic [31:0] full;
    full = {16'h0, a} << b;
    return {|full[31:16], full[15:0]};
  endfunction

  task automatic check_outputs();
    check("count", 32'(count), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() != 0) check("head", {15'h0, out_overflow, out_data}, {15'h0, mq[0]});
    else                check("head_zero", {15'h0, out_overflow, out_data}, 32'h0);
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
    check("ovf_count", 32'(ovf_count), 32'(m_cnt));
  endtask

  // One clock: check current outputs, drive inputs, advance the model at the edge.
  task automatic cyc(input logic v, input logic [16:0] e, input logic r, input logic c);
    bit wr, rd, ev;
    check_outputs();
    in_valid    = v;
    in_data     = e[15:0];
    in_overflow = e[16];
    out_ready   = r;
    clr_sticky  = c;
    wr = v && (mq.size() < DEPTH);
    rd = r && (mq.size() != 0);
    ev = wr && e[16];
    @(posedge clk);
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(e);
    if (ev)     m_sticky = 1'b1;
    else if (c) m_sticky = 1'b0;
    if (c)                     m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < 255) m_cnt++;
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_sticky", 32'(sticky_ovf), 0);
    check("rst_ovf_count", 32'(ovf_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // Stream 2 << 0..15 with the consumer always ready
    for (int b = 0; b < 16; b++) cyc(1'b1, shl(16'h0002, b), 1'b1, 1'b0);
    check("stream_last", {15'h0, out_overflow, out_data}, 32'h1_0000);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    check("stream_sticky", 32'(sticky_ovf), 1);
    check("stream_ovf_count", 32'(ovf_count), 1);
    check("stream_empty", 32'(out_valid), 0);

    // Fill with consumer stalled, then the full boundary
    for (int b = 0; b < 4; b++) cyc(1'b1, shl(16'h0002, b), 1'b0, 1'b0);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    cyc(1'b1, shl(16'h0002, 4), 1'b0, 1'b0);
    check("full_hold", 32'(count), 4);
    check("full_head", 32'(out_data), 32'h0002);
    cyc(1'b1, shl(16'h0002, 4), 1'b1, 1'b0);
    check("pop_no_write", 32'(count), 3);
    check("pop_head", 32'(out_data), 32'h0004);
    cyc(1'b1, shl(16'h0002, 4), 1'b0, 1'b0);
    check("refill_count", 32'(count), 4);

    // Drain to 2, then simultaneous read/write across the pointer wrap
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    check("two_left", 32'(count), 2);
    for (int i = 0; i < 10; i++) cyc(1'b1, {1'b0, 16'hA000 + 16'(i)}, 1'b1, 1'b0);
    check("rw_count", 32'(count), 2);
    check("rw_head", 32'(out_data), 32'hA008);
    while (mq.size() != 0) cyc(1'b0, 17'h0, 1'b1, 1'b0);

    // Empty: out_ready ignored, no same-cycle bypass
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    check("empty_ready_count", 32'(count), 0);
    in_valid = 1'b1; in_data = 16'h1234; in_overflow = 1'b0;
    #1 check("no_bypass", 32'(out_valid), 0);
    cyc(1'b1, 17'h0_1234, 1'b0, 1'b0);
    check("fwft_valid", 32'(out_valid), 1);
    check("fwft_data", 32'(out_data), 32'h1234);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);

    // Saturation of the overflow counter
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    check("clr_sticky", 32'(sticky_ovf), 0);
    check("clr_count", 32'(ovf_count), 0);
    for (int i = 0; i < 300; i++) cyc(1'b1, shl(16'hFFFF, 1), 1'b1, 1'b0);
    check("sat_count", 32'(ovf_count), 255);
    check("sat_sticky", 32'(sticky_ovf), 1);
    cyc(1'b1, shl(16'hFFFF, 1), 1'b1, 1'b1);
    check("clr_set_sticky", 32'(sticky_ovf), 1);
    check("clr_set_count", 32'(ovf_count), 1);
    while (mq.size() != 0) cyc(1'b0, 17'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three entries
    for (int b = 13; b < 16; b++) cyc(1'b1, shl(16'h0002, b), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_sticky", 32'(sticky_ovf), 0);
    check("arst_ovf_count", 32'(ovf_count), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("rst_hold_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_sticky = 1'b0; m_cnt = 0;
    #1 check("rerel_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    cyc(1'b1, 17'h0_5555, 1'b0, 1'b0);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
